// File: rtl/cp0_pkg.sv
// cp0_defs: shared definitions for the system-control coprocessor.
//   - CP0 register numbers (SR, Cause, EPC, PRId)
//   - bit positions of the architected fields inside SR and Cause
//   - exception codes written into Cause.ExcCode
package cp0_defs;

   // Register numbers as seen by mfc0/mtc0
   localparam logic [4:0] REG_SR    = 5'd12;
   localparam logic [4:0] REG_CAUSE = 5'd13;
   localparam logic [4:0] REG_EPC   = 5'd14;
   localparam logic [4:0] REG_PRID  = 5'd15;

   // SR fields
   localparam int SR_IM_HI = 15;
   localparam int SR_IM_LO = 10;
   localparam int SR_EXL   = 1;
   localparam int SR_IE    = 0;

   // Cause fields
   localparam int CAUSE_BD    = 31;
   localparam int CAUSE_IP_HI = 15;
   localparam int CAUSE_IP_LO = 10;
   localparam int CAUSE_EC_HI = 6;
   localparam int CAUSE_EC_LO = 2;

   // Exception codes
   localparam logic [4:0] EXC_INT     = 5'd0;
   localparam logic [4:0] EXC_ADEL    = 5'd4;
   localparam logic [4:0] EXC_ADES    = 5'd5;
   localparam logic [4:0] EXC_SYSCALL = 5'd8;
   localparam logic [4:0] EXC_RI      = 5'd10;
   localparam logic [4:0] EXC_OV      = 5'd12;

endpackage

// File: rtl/cp0.sv
// cp0: system-control coprocessor for the pipelined MIPS core.
// Holds SR, Cause, EPC and PRId, decides on exceptions/interrupts every
// cycle and drives the Req/EPCOut pair used by the fetch-address register.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low
//   A1         mfc0 read register number      -> Dout (combinational)
//   A2/Din/en  mtc0 write register / data / enable
//   VPC        PC of the instruction in the memory stage
//   BDIn       that instruction sits in a branch delay slot
//   ExcCodeIn  its exception code, 0 = none
//   HWInt      level-sensitive hardware interrupt lines
//   EXLClr     eret committing in the memory stage
//   Dout       read data for A1 (pre-edge register values, no bypass)
//   EPCOut     current EPC register
//   Req        exception/interrupt request, same cycle as its cause
//
// There is no handshake: Req is a single-cycle-valid level that fetch and
// the flush logic consume in the cycle it is asserted; the matching state
// update lands at the following clock edge.
module cp0
   import cp0_defs::*;
#(
   parameter logic [31:0] PRID = 32'h2023_0B03
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   input  logic [31:0] Din,
   input  logic        en,
   input  logic [31:0] VPC,
   input  logic        BDIn,
   input  logic [4:0]  ExcCodeIn,
   input  logic [5:0]  HWInt,
   input  logic        EXLClr,
   output logic [31:0] Dout,
   output logic [31:0] EPCOut,
   output logic        Req
);

   // Architected state
   logic [5:0]  im;
   logic        exl;
   logic        ie;
   logic        bd;
   logic [5:0]  ip;
   logic [4:0]  exc_code;
   logic [31:0] epc;

   logic        int_req;
   logic        exc_req;
   logic        any_req;
   logic [31:0] victim_pc;

   // While EXL is set nothing new is taken, which is what blocks nesting.
   assign int_req = (|(HWInt & im)) & ie & ~exl;
   assign exc_req = (ExcCodeIn != 5'd0) & ~exl;
   assign any_req = int_req | exc_req;
   assign Req     = any_req & reset;

   // Delay-slot victims restart at the branch; the subtraction wraps.
   assign victim_pc = BDIn ? (VPC - 32'd4) : VPC;

   always_ff @(posedge clk) begin
      if (!reset) begin
         im       <= 6'd0;
         exl      <= 1'b0;
         ie       <= 1'b0;
         bd       <= 1'b0;
         ip       <= 6'd0;
         exc_code <= 5'd0;
         epc      <= 32'd0;
      end else begin
         ip <= HWInt;
         if (any_req) begin
            // Exception entry wins over both mtc0 and eret.
            exl      <= 1'b1;
            bd       <= BDIn;
            exc_code <= int_req ? EXC_INT : ExcCodeIn;
            epc      <= {victim_pc[31:2], 2'b00};
         end else begin
            if (en && (A2 == REG_SR)) begin
               im  <= Din[SR_IM_HI:SR_IM_LO];
               exl <= Din[SR_EXL];
               ie  <= Din[SR_IE];
            end
            if (en && (A2 == REG_EPC)) begin
               epc <= Din;
            end
            // Placed after the mtc0 so eret's clear overrides a written EXL.
            if (EXLClr) begin
               exl <= 1'b0;
            end
         end
      end
   end

   logic [31:0] sr_val;
   logic [31:0] cause_val;

   always_comb begin
      sr_val                      = 32'd0;
      sr_val[SR_IM_HI:SR_IM_LO]   = im;
      sr_val[SR_EXL]              = exl;
      sr_val[SR_IE]               = ie;
   end

   always_comb begin
      cause_val                           = 32'd0;
      cause_val[CAUSE_BD]                 = bd;
      cause_val[CAUSE_IP_HI:CAUSE_IP_LO]  = ip;
      cause_val[CAUSE_EC_HI:CAUSE_EC_LO]  = exc_code;
   end

   always_comb begin
      Dout = 32'd0;
      case (A1)
         REG_SR:    Dout = sr_val;
         REG_CAUSE: Dout = cause_val;
         REG_EPC:   Dout = epc;
         REG_PRID:  Dout = PRID;
         default:   Dout = 32'd0;
      endcase
   end

   assign EPCOut = epc;

endmodule

// File: tb/tb_cp0.sv
// tb_cp0: directed self-checking bench for cp0.
module tb_cp0;

   logic        clk;
   logic        reset;
   logic [4:0]  A1;
   logic [4:0]  A2;
   logic [31:0] Din;
   logic        en;
   logic [31:0] VPC;
   logic        BDIn;
   logic [4:0]  ExcCodeIn;
   logic [5:0]  HWInt;
   logic        EXLClr;
   logic [31:0] Dout;
   logic [31:0] EPCOut;
   logic        Req;

   int n_checks = 0;
   int n_errors = 0;

   cp0 dut (
      .clk       (clk),
      .reset     (reset),
      .A1        (A1),
      .A2        (A2),
      .Din       (Din),
      .en        (en),
      .VPC       (VPC),
      .BDIn      (BDIn),
      .ExcCodeIn (ExcCodeIn),
      .HWInt     (HWInt),
      .EXLClr    (EXLClr),
      .Dout      (Dout),
      .EPCOut    (EPCOut),
      .Req       (Req)
   );

   // clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [4:0] addr, output logic [31:0] val);
      A1 = addr;
      #1;
      val = Dout;
   endtask

   task automatic chk_reg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
      logic [31:0] v;
      rd(addr, v);
      check_eq(tag, v, exp);
   endtask

   task automatic chk_req(input string tag, input logic exp);
      #1;
      check_eq(tag, {31'd0, Req}, {31'd0, exp});
   endtask

   task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
      en = 1'b1; A2 = addr; Din = data;
      tick();
      en = 1'b0; A2 = 5'd0; Din = 32'd0;
   endtask

   task automatic eret();
      EXLClr = 1'b1;
      tick();
      EXLClr = 1'b0;
   endtask

   initial begin
      reset = 1'b0; A1 = 5'd0; A2 = 5'd0; Din = 32'd0; en = 1'b0;
      VPC = 32'd0; BDIn = 1'b0; ExcCodeIn = 5'd8; HWInt = 6'd0; EXLClr = 1'b0;
      #1;

      // Reset: Req held low even with an exception code presented
      chk_req("rst_req0", 1'b0);
      tick();
      chk_req("rst_req1", 1'b0);
      tick();
      chk_req("rst_req2", 1'b0);
      chk_reg("rst_sr", 5'd12, 32'h0);
      chk_reg("rst_cause", 5'd13, 32'h0);
      chk_reg("rst_epc", 5'd14, 32'h0);
      chk_reg("prid", 5'd15, 32'h2023_0B03);
      chk_reg("unmapped_rd", 5'd3, 32'h0);
      reset = 1'b1; ExcCodeIn = 5'd0;
      tick();

      // Synchronous exception (RI), not in a delay slot
      VPC = 32'h3010; BDIn = 1'b0; ExcCodeIn = 5'd10;
      chk_req("exc_req", 1'b1);
      tick();
      chk_reg("exc_epc", 5'd14, 32'h3010);
      check_eq("exc_epcout", EPCOut, 32'h3010);
      chk_reg("exc_cause", 5'd13, 32'h0000_0028);
      chk_reg("exc_sr", 5'd12, 32'h0000_0002);
      chk_req("exc_no_nest", 1'b0);
      ExcCodeIn = 5'd0;
      eret();
      chk_reg("eret1_sr", 5'd12, 32'h0);

      // Delay-slot interrupt
      mtc0(5'd12, 32'h0000_0401);
      chk_reg("mtc0_sr", 5'd12, 32'h0000_0401);
      HWInt = 6'b000001; VPC = 32'h3024; BDIn = 1'b1;
      chk_req("int_req", 1'b1);
      tick();
      chk_reg("int_epc", 5'd14, 32'h3020);
      chk_reg("int_cause", 5'd13, 32'h8000_0400);
      chk_req("int_held_exl", 1'b0);

      // eret with interrupt still pending re-raises Req at once
      BDIn = 1'b0;
      eret();
      chk_reg("eret2_sr", 5'd12, 32'h0000_0401);
      chk_req("eret_reraise", 1'b1);
      HWInt = 6'd0;
      chk_req("int_dropped", 1'b0);

      // Masking: IE=1 but IM=0
      mtc0(5'd12, 32'h0000_0001);
      HWInt = 6'h3F;
      chk_req("masked", 1'b0);
      mtc0(5'd12, 32'h0000_FC01);
      chk_reg("sr_allim", 5'd12, 32'h0000_FC01);

      // Interrupt beats a simultaneous overflow exception
      HWInt = 6'h01; ExcCodeIn = 5'd12; VPC = 32'h3040; BDIn = 1'b0;
      chk_req("prio_req", 1'b1);
      tick();
      chk_reg("prio_cause", 5'd13, 32'h0000_0400);
      chk_reg("prio_epc", 5'd14, 32'h3040);
      HWInt = 6'd0; ExcCodeIn = 5'd0;
      eret();

      // mtc0 EPC in the same cycle as an exception is discarded
      ExcCodeIn = 5'd4; VPC = 32'h3100;
      en = 1'b1; A2 = 5'd14; Din = 32'hDEAD_BEEF;
      chk_req("coll_req", 1'b1);
      tick();
      en = 1'b0; A2 = 5'd0; Din = 32'd0; ExcCodeIn = 5'd0;
      chk_reg("coll_epc", 5'd14, 32'h3100);
      chk_reg("coll_cause", 5'd13, 32'h0000_0010);

      // mtc0 SR together with eret: written value lands, then EXL clears
      en = 1'b1; A2 = 5'd12; Din = 32'h0000_0403; EXLClr = 1'b1;
      tick();
      en = 1'b0; A2 = 5'd0; Din = 32'd0; EXLClr = 1'b0;
      chk_reg("mtc0_eret_sr", 5'd12, 32'h0000_0401);

      // Delay-slot wrap and low-bit forcing: 2 - 4 -> FFFF_FFFE -> FFFF_FFFC
      ExcCodeIn = 5'd5; VPC = 32'h0000_0002; BDIn = 1'b1;
      chk_req("wrap_req", 1'b1);
      tick();
      ExcCodeIn = 5'd0; BDIn = 1'b0;
      chk_reg("wrap_epc", 5'd14, 32'hFFFF_FFFC);
      chk_reg("wrap_cause", 5'd13, 32'h8000_0014);

      // Cause is not software-writable; EPC is while EXL=1
      mtc0(5'd13, 32'hFFFF_FFFF);
      chk_reg("cause_ro", 5'd13, 32'h8000_0014);
      mtc0(5'd14, 32'h1234_5677);
      chk_reg("epc_wr", 5'd14, 32'h1234_5677);
      check_eq("epcout_wr", EPCOut, 32'h1234_5677);

      // IP follows HWInt one cycle late, independent of EXL
      HWInt = 6'h2A;
      chk_reg("ip_before", 5'd13, 32'h8000_0014);
      tick();
      chk_reg("ip_after", 5'd13, 32'h8000_A814);
      chk_req("ip_no_req_exl", 1'b0);

      // Reset mid-run clears everything and blocks Req
      reset = 1'b0; ExcCodeIn = 5'd8;
      chk_req("rst2_req", 1'b0);
      tick();
      chk_reg("rst2_sr", 5'd12, 32'h0);
      chk_reg("rst2_epc", 5'd14, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Safety net against a stalled run.
   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
